// File: rtl/vgpr_retire_arbiter_pkg.sv
// Shared types and constants for the VGPR retire arbiter: source encodings,
// FIFO depth and the {wfid, addr, mask} retire entry record.
package vgpr_retire_arbiter_pkg;
    localparam int NUM_RETIRE_SRC    = 3;
    localparam int RETIRE_FIFO_DEPTH = 2;
    localparam int WFID_W            = 6;
    localparam int VGPR_ADDR_LENGTH  = 10;
    localparam int MASK_W            = 4;
    localparam int RETIRE_ENTRY_W    = WFID_W + VGPR_ADDR_LENGTH + MASK_W;

    localparam logic [1:0] SRC_SIMD = 2'd0;
    localparam logic [1:0] SRC_SIMF = 2'd1;
    localparam logic [1:0] SRC_LSU  = 2'd2;

    typedef struct packed {
        logic [WFID_W-1:0]           wfid;
        logic [VGPR_ADDR_LENGTH-1:0] addr;
        logic [MASK_W-1:0]           mask;
    } retire_entry_t;

    // (base + off) mod 3 for the round-robin search order
    function automatic logic [1:0] src_add(input logic [1:0] base, input logic [1:0] off);
        logic [2:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        return (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
    endfunction
endpackage

// File: rtl/vgpr_retire_arbiter_if.sv
// Retire request / retire output bundle between the VALU/LSU sources,
// the arbiter and the scoreboard comparator.
interface vgpr_retire_arbiter_if;
    import vgpr_retire_arbiter_pkg::*;

    logic [NUM_RETIRE_SRC-1:0]                        req_valid;
    logic [NUM_RETIRE_SRC-1:0][WFID_W-1:0]            req_wfid;
    logic [NUM_RETIRE_SRC-1:0][VGPR_ADDR_LENGTH-1:0]  req_vgpr_addr;
    logic [NUM_RETIRE_SRC-1:0][MASK_W-1:0]            req_mask;
    logic [NUM_RETIRE_SRC-1:0]                        req_ready;
    logic                                             sb_stall;
    logic                                             retire_valid;
    logic [WFID_W-1:0]                                retire_wfid;
    logic [VGPR_ADDR_LENGTH-1:0]                      retired_operand_addr;
    logic [MASK_W-1:0]                                retired_operand_mask;
    logic [1:0]                                       retire_src;

    modport master (
        output req_valid, req_wfid, req_vgpr_addr, req_mask, sb_stall,
        input  req_ready, retire_valid, retire_wfid, retired_operand_addr,
               retired_operand_mask, retire_src
    );

    modport slave (
        input  req_valid, req_wfid, req_vgpr_addr, req_mask, sb_stall,
        output req_ready, retire_valid, retire_wfid, retired_operand_addr,
               retired_operand_mask, retire_src
    );
endinterface

// File: rtl/vgpr_retire_arbiter_skid_fifo.sv
// Two-entry count-based FIFO holding pending retires for one source.
module retire_skid_fifo
    import vgpr_retire_arbiter_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  retire_entry_t push_data,
    output retire_entry_t head,
    output logic          full,
    output logic          empty
);
    retire_entry_t mem_q [RETIRE_FIFO_DEPTH];
    retire_entry_t mem_d [RETIRE_FIFO_DEPTH];
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [1:0]    count_q, count_d;
    logic          push_ok, pop_ok;

    assign full    = (count_q == 2'(RETIRE_FIFO_DEPTH));
    assign empty   = (count_q == 2'd0);
    assign head    = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop_ok) rd_ptr_d = ~rd_ptr_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < RETIRE_FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/vgpr_retire_arbiter.sv
// Arbitrates SIMD/SIMF/LSU retires into one registered retire port.
// VGPR_RETIRE_LSU_PRIORITY_EN selects fixed LSU > SIMF > SIMD priority instead of round-robin.
module vgpr_retire_arbiter
    import vgpr_retire_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    vgpr_retire_arbiter_if.slave  bus
);
    logic [NUM_RETIRE_SRC-1:0] push, pop, full, empty;
    retire_entry_t [NUM_RETIRE_SRC-1:0] head;

    for (genvar g = 0; g < NUM_RETIRE_SRC; g++) begin : g_src
        retire_entry_t push_data;
        assign push_data = {bus.req_wfid[g], bus.req_vgpr_addr[g], bus.req_mask[g]};
        // An all-zero mask retires nothing, so it is accepted and dropped here.
        assign push[g]   = bus.req_valid[g] && !full[g] && (bus.req_mask[g] != '0);

        retire_skid_fifo u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (push[g]),
            .pop       (pop[g]),
            .push_data (push_data),
            .head      (head[g]),
            .full      (full[g]),
            .empty     (empty[g])
        );
    end

    assign bus.req_ready = ~full;

    logic          retire_valid_q, retire_valid_d;
    retire_entry_t retire_q, retire_d;
    logic [1:0]    retire_src_q, retire_src_d;
    logic          load, grant_found;
    logic [1:0]    grant_idx;

    assign load = !retire_valid_q || !bus.sb_stall;

`ifdef VGPR_RETIRE_LSU_PRIORITY_EN
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = SRC_SIMD;
        // Ascending scan, last hit wins: highest source index has priority.
        for (int i = 0; i < NUM_RETIRE_SRC; i++) begin
            if (!empty[i]) begin
                grant_found = 1'b1;
                grant_idx   = 2'(i);
            end
        end
    end
`else
    logic [1:0] rr_ptr_q, rr_ptr_d;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = SRC_SIMD;
        // Descending scan over offsets so the nearest candidate after rr_ptr wins.
        for (int i = NUM_RETIRE_SRC - 1; i >= 0; i--) begin
            if (!empty[src_add(rr_ptr_q, 2'(i))]) begin
                grant_found = 1'b1;
                grant_idx   = src_add(rr_ptr_q, 2'(i));
            end
        end
        rr_ptr_d = rr_ptr_q;
        if (load && grant_found) rr_ptr_d = src_add(grant_idx, 2'd1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) rr_ptr_q <= 2'd0;
        else        rr_ptr_q <= rr_ptr_d;
    end
`endif

    always_comb begin
        pop            = '0;
        retire_valid_d = retire_valid_q;
        retire_d       = retire_q;
        retire_src_d   = retire_src_q;
        if (load) begin
            retire_valid_d = grant_found;
            if (grant_found) begin
                pop[grant_idx] = 1'b1;
                retire_d       = head[grant_idx];
                retire_src_d   = grant_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retire_valid_q <= 1'b0;
            retire_q       <= '0;
            retire_src_q   <= 2'd0;
        end else begin
            retire_valid_q <= retire_valid_d;
            retire_q       <= retire_d;
            retire_src_q   <= retire_src_d;
        end
    end

    assign bus.retire_valid         = retire_valid_q;
    assign bus.retire_wfid          = retire_q.wfid;
    assign bus.retired_operand_addr = retire_q.addr;
    assign bus.retired_operand_mask = retire_q.mask;
    assign bus.retire_src           = retire_src_q;
endmodule

// File: tb/tb_vgpr_retire_arbiter.sv
// Bench for vgpr_retire_arbiter: per-source expected queues filled on accepted
// requests and drained on each freshly loaded retire, plus per-scenario checks.
module tb_vgpr_retire_arbiter;
    import vgpr_retire_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vgpr_retire_arbiter_if bus ();

    vgpr_retire_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int passed = 0;
    retire_entry_t exp_q [NUM_RETIRE_SRC][$];
    bit fresh = 1'b0;

    // One clock: sample at the falling edge (scoreboard), return 1 time unit after the rising edge.
    task automatic cyc();
        retire_entry_t e, got;
        int s;
        @(negedge clk);
        if (!rst_n) begin
            for (int i = 0; i < NUM_RETIRE_SRC; i++) exp_q[i].delete();
            fresh = 1'b0;
        end else begin
            if (bus.retire_valid && fresh) begin
                checks++;
                s   = int'(bus.retire_src);
                got = {bus.retire_wfid, bus.retired_operand_addr, bus.retired_operand_mask};
                if (s >= NUM_RETIRE_SRC || exp_q[s].size() == 0) begin
                    $display("FAIL sb_unexpected src=%0d payload=%05h none expected", s, got);
                end else begin
                    e = exp_q[s].pop_front();
                    if (got !== e) $display("FAIL sb_payload src=%0d got %05h exp %05h", s, got, e);
                    else passed++;
                end
            end
            for (int i = 0; i < NUM_RETIRE_SRC; i++)
                if (bus.req_valid[i] && bus.req_ready[i] && bus.req_mask[i] != 4'b0000)
                    exp_q[i].push_back({bus.req_wfid[i], bus.req_vgpr_addr[i], bus.req_mask[i]});
            fresh = !bus.retire_valid || !bus.sb_stall;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        bus.req_valid     = '0;
        bus.req_wfid      = '0;
        bus.req_vgpr_addr = '0;
        bus.req_mask      = '0;
    endtask

    task automatic drive(input int s, input logic [5:0] w, input logic [9:0] a, input logic [3:0] m);
        bus.req_valid[s]     = 1'b1;
        bus.req_wfid[s]      = w;
        bus.req_vgpr_addr[s] = a;
        bus.req_mask[s]      = m;
    endtask

    task automatic do_reset();
        clear_reqs();
        bus.sb_stall = 1'b0;
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    function automatic int pending();
        return exp_q[0].size() + exp_q[1].size() + exp_q[2].size();
    endfunction

    task automatic test_reset();
        do_reset();
        checks++; if (bus.retire_valid !== 1'b0) $display("FAIL rst_valid got %0b exp 0", bus.retire_valid); else passed++;
        checks++; if (bus.retire_wfid !== 6'd0) $display("FAIL rst_wfid got %0h exp 0", bus.retire_wfid); else passed++;
        checks++; if (bus.retired_operand_addr !== 10'd0) $display("FAIL rst_addr got %0h exp 0", bus.retired_operand_addr); else passed++;
        checks++; if (bus.retired_operand_mask !== 4'd0) $display("FAIL rst_mask got %0h exp 0", bus.retired_operand_mask); else passed++;
        checks++; if (bus.retire_src !== 2'd0) $display("FAIL rst_src got %0d exp 0", bus.retire_src); else passed++;
        checks++; if (bus.req_ready !== 3'b111) $display("FAIL rst_ready got %03b exp 111", bus.req_ready); else passed++;
    endtask

    task automatic test_single();
        drive(0, 6'd5, 10'h010, 4'b0011);
        cyc();
        clear_reqs();
        checks++; if (bus.retire_valid !== 1'b0) $display("FAIL single_n1 got %0b exp 0", bus.retire_valid); else passed++;
        cyc();
        checks++;
        if ({bus.retire_valid, bus.retire_wfid, bus.retired_operand_addr, bus.retired_operand_mask, bus.retire_src} !==
            {1'b1, 6'd5, 10'h010, 4'b0011, 2'd0})
            $display("FAIL single_n2 got v=%0b w=%0d a=%0h m=%0b s=%0d exp v=1 w=5 a=10 m=0011 s=0",
                     bus.retire_valid, bus.retire_wfid, bus.retired_operand_addr, bus.retired_operand_mask, bus.retire_src);
        else passed++;
        cyc();
        checks++; if (bus.retire_valid !== 1'b0) $display("FAIL single_n3 got %0b exp 0", bus.retire_valid); else passed++;
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_src;
        bit saw_ready0_lo, saw_ready0_hi;
        logic [3:0] m;
        int k;
        do_reset();
        exp_src = 2'd0;
        saw_ready0_lo = 1'b0;
        saw_ready0_hi = 1'b0;
        for (int t = 0; t < 15; t++) begin
            for (int s = 0; s < NUM_RETIRE_SRC; s++) begin
                k = $urandom_range(0, 2);
                m = (k == 0) ? 4'b0001 : (k == 1) ? 4'b0011 : 4'b1111;
                drive(s, 6'($urandom), 10'($urandom), m);
            end
            cyc();
            if (bus.req_ready[0]) saw_ready0_hi = 1'b1; else saw_ready0_lo = 1'b1;
            if (t >= 1) begin
`ifdef VGPR_RETIRE_LSU_PRIORITY_EN
                exp_src = SRC_LSU;
`endif
                checks++;
                if (bus.retire_valid !== 1'b1 || bus.retire_src !== exp_src)
                    $display("FAIL rr_grant t=%0d got v=%0b src=%0d exp v=1 src=%0d", t, bus.retire_valid, bus.retire_src, exp_src);
                else passed++;
                exp_src = src_add(exp_src, 2'd1);
            end
        end
        clear_reqs();
        checks++;
        if (!(saw_ready0_lo && saw_ready0_hi))
            $display("FAIL rr_ready_toggle got lo=%0b hi=%0b exp lo=1 hi=1", saw_ready0_lo, saw_ready0_hi);
        else passed++;
        for (int t = 0; t < 30 && (pending() != 0 || bus.retire_valid); t++) cyc();
        checks++; if (pending() != 0) $display("FAIL rr_drain got %0d pending exp 0", pending()); else passed++;
    endtask

    task automatic test_stall();
        retire_entry_t hold, cur;
        int accepts;
        bit rdy;
        do_reset();
        drive(0, 6'd1, 10'h100, 4'b1111);
        cyc();
        clear_reqs();
        cyc();
        hold = {bus.retire_wfid, bus.retired_operand_addr, bus.retired_operand_mask};
        checks++; if (bus.retire_valid !== 1'b1) $display("FAIL stall_pre got %0b exp 1", bus.retire_valid); else passed++;
        bus.sb_stall = 1'b1;
        accepts = 0;
        drive(0, 6'd10, 10'h200, 4'b0001);
        for (int t = 0; t < 4; t++) begin
            rdy = bus.req_ready[0];
            cyc();
            if (rdy) begin
                accepts++;
                drive(0, 6'(10 + accepts), 10'(10'h200 + accepts), 4'b0001);
            end
            cur = {bus.retire_wfid, bus.retired_operand_addr, bus.retired_operand_mask};
            checks++;
            if (bus.retire_valid !== 1'b1 || cur !== hold)
                $display("FAIL stall_hold t=%0d got v=%0b %05h exp v=1 %05h", t, bus.retire_valid, cur, hold);
            else passed++;
            if (accepts >= 2) begin
                checks++; if (bus.req_ready[0] !== 1'b0) $display("FAIL stall_full t=%0d got %0b exp 0", t, bus.req_ready[0]); else passed++;
            end
        end
        checks++; if (accepts != 2) $display("FAIL stall_accepts got %0d exp 2", accepts); else passed++;
        clear_reqs();
        bus.sb_stall = 1'b0;
        for (int t = 0; t < 10; t++) cyc();
        checks++; if (pending() != 0) $display("FAIL stall_drain got %0d pending exp 0", pending()); else passed++;
    endtask

    task automatic test_zero_mask();
        int n2;
        logic [9:0] a;
        logic [3:0] m;
        drive(2, 6'd7, 10'h155, 4'b0000);
        cyc();
        clear_reqs();
        drive(2, 6'd9, 10'h3FE, 4'b1111);
        cyc();
        clear_reqs();
        n2 = 0;
        a = '0;
        m = '0;
        for (int t = 0; t < 6; t++) begin
            if (bus.retire_valid && bus.retire_src == SRC_LSU) begin
                n2++;
                a = bus.retired_operand_addr;
                m = bus.retired_operand_mask;
            end
            cyc();
        end
        checks++; if (n2 != 1) $display("FAIL zmask_count got %0d exp 1", n2); else passed++;
        checks++; if ({a, m} !== {10'h3FE, 4'b1111}) $display("FAIL zmask_payload got a=%0h m=%0b exp a=3fe m=1111", a, m); else passed++;
    endtask

    task automatic test_reset_mid();
        int seen;
        do_reset();
        drive(0, 6'd20, 10'h020, 4'b0001);
        cyc();
        clear_reqs();
        cyc();
        bus.sb_stall = 1'b1;
        drive(0, 6'd21, 10'h021, 4'b0011);
        drive(1, 6'd22, 10'h022, 4'b1111);
        cyc();
        cyc();
        clear_reqs();
        checks++; if (bus.retire_valid !== 1'b1) $display("FAIL rmid_pre got %0b exp 1", bus.retire_valid); else passed++;
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        bus.sb_stall = 1'b0;
        checks++; if (bus.retire_valid !== 1'b0) $display("FAIL rmid_valid got %0b exp 0", bus.retire_valid); else passed++;
        checks++; if (bus.req_ready !== 3'b111) $display("FAIL rmid_ready got %03b exp 111", bus.req_ready); else passed++;
        seen = 0;
        for (int t = 0; t < 6; t++) begin
            cyc();
            if (bus.retire_valid) seen++;
        end
        checks++; if (seen != 0) $display("FAIL rmid_ghost got %0d retires exp 0", seen); else passed++;
    endtask

    initial begin
        clear_reqs();
        bus.sb_stall = 1'b0;
        rst_n = 1'b0;
        cyc();
        cyc();
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_zero_mask();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
